// File: rtl/cache_pkg.sv
// Shared encodings for the cache operation controller: request opcodes,
// response status codes and the sequencer's state set.
package cache_pkg;

    typedef enum logic [1:0] {
        OP_GET  = 2'd0,
        OP_PUT  = 2'd1,
        OP_DEL  = 2'd2,
        OP_RSVD = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_OK        = 2'd0,
        ST_NOT_FOUND = 2'd1,
        ST_FULL      = 2'd2,
        ST_INVALID   = 2'd3
    } status_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_CHECK  = 3'd2,
        S_WRITE  = 3'd3,
        S_DELETE = 3'd4,
        S_RESP   = 3'd5
    } state_e;

endpackage

// File: rtl/free_slot_finder.sv
// Lowest-free-entry picker: returns the one-hot position of the lowest zero
// bit of the used-entry mask, and whether any free entry exists at all.
module free_slot_finder #(
    parameter int NUM_ENTRIES = 16
) (
    input  logic [NUM_ENTRIES-1:0] used_entries_i,
    output logic [NUM_ENTRIES-1:0] slot_o,
    output logic                   found_o
);

    // Priority scan from bit 0 upwards; first zero bit wins.
    always_comb begin
        slot_o  = '0;
        found_o = 1'b0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (!used_entries_i[i] && !found_o) begin
                slot_o[i] = 1'b1;
                found_o   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cache_op_controller.sv
// Initiator-side sequencer for the cache memory_block. Takes one GET/PUT/DEL
// request at a time, runs a lookup through the block's registered match
// outputs, performs the write or delete if needed, and returns one response.
// The mem_* lines decode only from state and captured registers, so request
// inputs never reach the memory block combinationally.
module cache_op_controller
    import cache_pkg::*;
#(
    parameter int NUM_ENTRIES = 16,
    parameter int KEY_WIDTH   = 16,
    parameter int VALUE_WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [1:0]             req_op,
    input  logic [KEY_WIDTH-1:0]   req_key,
    input  logic [VALUE_WIDTH-1:0] req_value,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [1:0]             resp_status,
    output logic [VALUE_WIDTH-1:0] resp_value,
    output logic [NUM_ENTRIES-1:0] resp_index,
    output logic                   mem_write,
    output logic                   mem_delete,
    output logic                   mem_select_by_index,
    output logic [KEY_WIDTH-1:0]   mem_key,
    output logic [VALUE_WIDTH-1:0] mem_value,
    output logic [NUM_ENTRIES-1:0] mem_index,
    input  logic                   mem_hit,
    input  logic [NUM_ENTRIES-1:0] mem_index_out,
    input  logic [VALUE_WIDTH-1:0] mem_value_out,
    input  logic [NUM_ENTRIES-1:0] mem_used_entries
);

    state_e                 state_q,  state_d;
    op_e                    op_q,     op_d;
    logic [KEY_WIDTH-1:0]   key_q,    key_d;
    logic [VALUE_WIDTH-1:0] value_q,  value_d;
    logic [NUM_ENTRIES-1:0] idx_q,    idx_d;
    status_e                status_q, status_d;
    logic [VALUE_WIDTH-1:0] rvalue_q, rvalue_d;
    logic [NUM_ENTRIES-1:0] rindex_q, rindex_d;
    // Registered so it stays low through reset and rises on the first edge after release.
    logic                   ready_q,  ready_d;

    logic [NUM_ENTRIES-1:0] free_slot;
    logic                   free_found;

    free_slot_finder #(
        .NUM_ENTRIES(NUM_ENTRIES)
    ) u_free_slot_finder (
        .used_entries_i(mem_used_entries),
        .slot_o        (free_slot),
        .found_o       (free_found)
    );

    // State, capture and response registers; async reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= OP_GET;
            key_q    <= '0;
            value_q  <= '0;
            idx_q    <= '0;
            status_q <= ST_OK;
            rvalue_q <= '0;
            rindex_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            key_q    <= key_d;
            value_q  <= value_d;
            idx_q    <= idx_d;
            status_q <= status_d;
            rvalue_q <= rvalue_d;
            rindex_q <= rindex_d;
            ready_q  <= ready_d;
        end
    end

    // Next-state and register-update decisions for each sequencer step.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        key_d    = key_q;
        value_d  = value_q;
        idx_d    = idx_q;
        status_d = status_q;
        rvalue_d = rvalue_q;
        rindex_d = rindex_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid && ready_q) begin
                    op_d     = op_e'(req_op);
                    key_d    = req_key;
                    value_d  = req_value;
                    idx_d    = '0;
                    status_d = ST_OK;
                    rvalue_d = '0;
                    rindex_d = '0;
                    if (req_key == '0 || op_e'(req_op) == OP_RSVD) begin
                        status_d = ST_INVALID;
                        state_d  = S_RESP;
                    end else begin
                        state_d  = S_LOOKUP;
                    end
                end
            end
            S_LOOKUP: state_d = S_CHECK;
            S_CHECK: begin
                // mem_hit / mem_index_out now reflect key_q presented during LOOKUP.
                case (op_q)
                    OP_GET: begin
                        if (mem_hit) begin
                            status_d = ST_OK;
                            rvalue_d = mem_value_out;
                            rindex_d = mem_index_out;
                        end else begin
                            status_d = ST_NOT_FOUND;
                        end
                        state_d = S_RESP;
                    end
                    OP_PUT: begin
                        if (mem_hit) begin
                            idx_d   = mem_index_out;
                            state_d = S_WRITE;
                        end else if (free_found) begin
                            idx_d   = free_slot;
                            state_d = S_WRITE;
                        end else begin
                            status_d = ST_FULL;
                            state_d  = S_RESP;
                        end
                    end
                    OP_DEL: begin
                        if (mem_hit) begin
                            idx_d   = mem_index_out;
                            state_d = S_DELETE;
                        end else begin
                            status_d = ST_NOT_FOUND;
                            state_d  = S_RESP;
                        end
                    end
                    default: begin
                        status_d = ST_INVALID;
                        state_d  = S_RESP;
                    end
                endcase
            end
            S_WRITE, S_DELETE: begin
                status_d = ST_OK;
                rindex_d = idx_q;
                state_d  = S_RESP;
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        ready_d = (state_d == S_IDLE);
    end

    // Output decode from registered state and captured values only.
    always_comb begin
        req_ready           = ready_q;
        resp_valid          = (state_q == S_RESP);
        resp_status         = status_q;
        resp_value          = rvalue_q;
        resp_index          = rindex_q;
        mem_write           = 1'b0;
        mem_delete          = 1'b0;
        mem_select_by_index = 1'b0;
        mem_key             = '0;
        mem_value           = '0;
        mem_index           = '0;
        case (state_q)
            S_LOOKUP, S_CHECK: mem_key = key_q;
            S_WRITE: begin
                mem_write = 1'b1;
                mem_key   = key_q;
                mem_value = value_q;
                mem_index = idx_q;
            end
            S_DELETE: begin
                mem_delete = 1'b1;
                mem_key    = key_q;
                mem_index  = idx_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cache_op_controller.sv
// Bench for cache_op_controller: a behavioural memory_block stand-in feeds the
// DUT, and an abstract key/slot model predicts every response, latency and
// memory side effect.
module tb_cache_op_controller;
    localparam int N  = 16;
    localparam int KW = 16;
    localparam int VW = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [1:0]    req_op = '0;
    logic [KW-1:0] req_key = '0;
    logic [VW-1:0] req_value = '0;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic [1:0]    resp_status;
    logic [VW-1:0] resp_value;
    logic [N-1:0]  resp_index;
    logic          mem_write, mem_delete, mem_select_by_index;
    logic [KW-1:0] mem_key;
    logic [VW-1:0] mem_value;
    logic [N-1:0]  mem_index;
    logic          mem_hit = 1'b0;
    logic [N-1:0]  mem_index_out = '0;
    logic [VW-1:0] mem_value_out = '0;
    logic [N-1:0]  m_used = '0;

    int n_pass = 0;
    int n_checks = 0;

    always #5 clk = ~clk;

    cache_op_controller #(.NUM_ENTRIES(N), .KEY_WIDTH(KW), .VALUE_WIDTH(VW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_key(req_key), .req_value(req_value),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_status(resp_status),
        .resp_value(resp_value), .resp_index(resp_index),
        .mem_write(mem_write), .mem_delete(mem_delete),
        .mem_select_by_index(mem_select_by_index), .mem_key(mem_key),
        .mem_value(mem_value), .mem_index(mem_index),
        .mem_hit(mem_hit), .mem_index_out(mem_index_out),
        .mem_value_out(mem_value_out), .mem_used_entries(m_used)
    );

    // memory_block stand-in: registered key match, writes/deletes at the edge.
    logic [KW-1:0] m_key [N];
    logic [VW-1:0] m_val [N];
    always @(posedge clk) begin
        mem_hit       <= 1'b0;
        mem_index_out <= '0;
        mem_value_out <= '0;
        for (int i = 0; i < N; i++) begin
            if (m_used[i] && mem_key != '0 && m_key[i] == mem_key) begin
                mem_hit          <= 1'b1;
                mem_index_out[i] <= 1'b1;
                mem_value_out    <= m_val[i];
            end
            if (mem_write && mem_index[i]) begin
                m_key[i]  <= mem_key;
                m_val[i]  <= mem_value;
                m_used[i] <= 1'b1;
            end
            if (mem_delete && mem_index[i]) m_used[i] <= 1'b0;
        end
    end

    // Reference model: which key lives in which slot, and its value.
    bit            mdl_used [N];
    logic [KW-1:0] mdl_key  [N];
    logic [VW-1:0] mdl_val  [N];

    function automatic logic [N-1:0] mdl_mask();
        logic [N-1:0] m;
        for (int i = 0; i < N; i++) m[i] = mdl_used[i];
        return m;
    endfunction

    task automatic model(input logic [1:0] op, input logic [KW-1:0] key, input logic [VW-1:0] val,
                         output logic [1:0] st, output logic [VW-1:0] ev, output logic [N-1:0] ei,
                         output int lat, output int wr, output int dl);
        int hs;
        int fs;
        hs = -1; fs = -1;
        ev = '0; ei = '0; wr = 0; dl = 0; st = 2'd0; lat = 0;
        for (int i = 0; i < N; i++) if (mdl_used[i] && mdl_key[i] == key) hs = i;
        for (int i = N - 1; i >= 0; i--) if (!mdl_used[i]) fs = i;
        if (key == '0 || op == 2'd3) begin
            st = 2'd3; lat = 1;
        end else if (op == 2'd0) begin
            lat = 3;
            if (hs >= 0) begin st = 2'd0; ev = mdl_val[hs]; ei[hs] = 1'b1; end
            else st = 2'd1;
        end else if (op == 2'd1) begin
            if (hs < 0) hs = fs;
            if (hs < 0) begin st = 2'd2; lat = 3; end
            else begin
                st = 2'd0; lat = 4; wr = 1; ei[hs] = 1'b1;
                mdl_used[hs] = 1'b1; mdl_key[hs] = key; mdl_val[hs] = val;
            end
        end else begin
            if (hs >= 0) begin st = 2'd0; lat = 4; dl = 1; ei[hs] = 1'b1; mdl_used[hs] = 1'b0; end
            else begin st = 2'd1; lat = 3; end
        end
    endtask

    // Drives one request, observes the DUT until the response, then consumes it.
    task automatic send(input logic [1:0] op, input logic [KW-1:0] key, input logic [VW-1:0] val,
                        input int hold,
                        output logic [1:0] st, output logic [VW-1:0] rv, output logic [N-1:0] ri,
                        output int lat, output int nwr, output int ndl, output logic [N-1:0] opidx,
                        output int nboth, output int nkey, output bit stable);
        int t;
        st = '0; rv = '0; ri = '0; lat = -1; nwr = 0; ndl = 0; opidx = '0;
        nboth = 0; nkey = 0; stable = 1'b1;
        t = 0;
        while (!req_ready && t < 20) begin @(posedge clk); #1; t++; end
        req_valid = 1'b1; req_op = op; req_key = key; req_value = val;
        @(posedge clk); #1;
        req_valid = 1'b0; req_op = 2'($urandom); req_key = KW'($urandom); req_value = {$urandom, $urandom};
        for (int c = 1; c <= 20; c++) begin
            if (mem_write) begin nwr++; opidx = mem_index; end
            if (mem_delete) begin ndl++; opidx = mem_index; end
            if (mem_write && mem_delete) nboth++;
            if (mem_key != '0) nkey++;
            if (resp_valid) begin lat = c; break; end
            @(posedge clk); #1;
        end
        if (lat > 0) begin
            st = resp_status; rv = resp_value; ri = resp_index;
            for (int h = 0; h < hold; h++) begin
                @(posedge clk); #1;
                if (!resp_valid || req_ready || resp_status !== st || resp_value !== rv || resp_index !== ri)
                    stable = 1'b0;
            end
            resp_ready = 1'b1;
            @(posedge clk); #1;
            resp_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({req_ready, resp_valid, resp_status, resp_value, resp_index, mem_write, mem_delete,
             mem_select_by_index, mem_key, mem_value, mem_index} !== '0)
            $display("FAIL reset_outputs: got ready=%b rv=%b st=%0d wr=%b del=%b key=%h, want all 0",
                     req_ready, resp_valid, resp_status, mem_write, mem_delete, mem_key);
        else n_pass++;
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 1'b0) $display("FAIL reset_ready_early: got %b want 0", req_ready);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (req_ready !== 1'b1) $display("FAIL reset_ready_rise: got %b want 1", req_ready);
        else n_pass++;
    endtask

    logic [1:0]    d_op  [9] = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd0, 2'd3, 2'd2, 2'd1};
    logic [KW-1:0] d_key [9] = '{16'h5, 16'h1, 16'h1, 16'h1, 16'h1, 16'h0, 16'h7, 16'h5, 16'h0};
    logic [VW-1:0] d_val [9] = '{64'h0, 64'hAA, 64'h0, 64'hBB, 64'h0, 64'h0, 64'h3, 64'h0, 64'h1};

    task automatic test_directed();
        logic [1:0] st, est; logic [VW-1:0] rv, ev; logic [N-1:0] ri, ei, opidx;
        int lat, elat, nwr, ndl, ewr, edl, nboth, nkey; bit stable;
        for (int i = 0; i < 9; i++) begin
            model(d_op[i], d_key[i], d_val[i], est, ev, ei, elat, ewr, edl);
            send(d_op[i], d_key[i], d_val[i], 0, st, rv, ri, lat, nwr, ndl, opidx, nboth, nkey, stable);
            n_checks++;
            if ({st, rv, ri} !== {est, ev, ei})
                $display("FAIL directed[%0d] resp: got st=%0d val=%h idx=%h want st=%0d val=%h idx=%h",
                         i, st, rv, ri, est, ev, ei);
            else n_pass++;
            n_checks++;
            if (lat !== elat) $display("FAIL directed[%0d] latency: got %0d want %0d", i, lat, elat);
            else n_pass++;
            n_checks++;
            if (nwr !== ewr || ndl !== edl || nboth !== 0 || opidx !== ((ewr + edl) > 0 ? ei : '0)
                || (est == 2'd3 && nkey != 0))
                $display("FAIL directed[%0d] memops: got wr=%0d del=%0d idx=%h keycyc=%0d want wr=%0d del=%0d",
                         i, nwr, ndl, opidx, nkey, ewr, edl);
            else n_pass++;
            n_checks++;
            if (m_used !== mdl_mask()) $display("FAIL directed[%0d] used: got %h want %h", i, m_used, mdl_mask());
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_write();
        int t, nresp; logic [N-1:0] used_before;
        used_before = m_used;
        req_valid = 1'b1; req_op = 2'd1; req_key = 16'h55; req_value = 64'h1234;
        @(posedge clk); #1;
        req_valid = 1'b0;
        t = 0;
        while (!mem_write && t < 10) begin @(posedge clk); #1; t++; end
        n_checks++;
        if (mem_write !== 1'b1) $display("FAIL midrst_reach_write: got mem_write=%b want 1", mem_write);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (mem_write !== 1'b0 || mem_delete !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b0)
            $display("FAIL midrst_drop: got wr=%b del=%b rv=%b ready=%b want 0", mem_write, mem_delete,
                     resp_valid, req_ready);
        else n_pass++;
        repeat (2) @(posedge clk);
        #1; rst_n = 1'b1;
        nresp = 0;
        repeat (4) begin @(posedge clk); #1; if (resp_valid) nresp++; end
        n_checks++;
        if (nresp !== 0 || req_ready !== 1'b1 || m_used !== used_before)
            $display("FAIL midrst_after: got resp=%0d ready=%b used=%h want 0 1 %h", nresp, req_ready,
                     m_used, used_before);
        else n_pass++;
    endtask

    task automatic test_resp_hold();
        logic [1:0] st, est; logic [VW-1:0] rv, ev; logic [N-1:0] ri, ei, opidx;
        int lat, elat, nwr, ndl, ewr, edl, nboth, nkey; bit stable;
        model(2'd0, 16'h1, '0, est, ev, ei, elat, ewr, edl);
        send(2'd0, 16'h1, '0, 5, st, rv, ri, lat, nwr, ndl, opidx, nboth, nkey, stable);
        n_checks++;
        if ({st, rv, ri} !== {est, ev, ei})
            $display("FAIL hold resp: got st=%0d val=%h idx=%h want st=%0d val=%h idx=%h", st, rv, ri, est, ev, ei);
        else n_pass++;
        n_checks++;
        if (stable !== 1'b1) $display("FAIL hold stable: got %b want 1", stable);
        else n_pass++;
    endtask

    task automatic test_fill_full();
        logic [1:0] st, est, op; logic [VW-1:0] rv, ev, val; logic [N-1:0] ri, ei, opidx;
        logic [KW-1:0] key;
        int lat, elat, nwr, ndl, ewr, edl, nboth, nkey; bit stable;
        for (int i = 0; i < 18; i++) begin
            op = 2'd1; key = 16'h100 + KW'(i); val = {$urandom, $urandom};
            if (i == 15) key = 16'h200;
            if (i == 16) begin op = 2'd2; key = mdl_key[8]; end
            if (i == 17) key = 16'h201;
            model(op, key, val, est, ev, ei, elat, ewr, edl);
            send(op, key, val, 0, st, rv, ri, lat, nwr, ndl, opidx, nboth, nkey, stable);
            n_checks++;
            if ({st, rv, ri} !== {est, ev, ei})
                $display("FAIL fill[%0d] resp: got st=%0d val=%h idx=%h want st=%0d val=%h idx=%h",
                         i, st, rv, ri, est, ev, ei);
            else n_pass++;
            n_checks++;
            if (lat !== elat) $display("FAIL fill[%0d] latency: got %0d want %0d", i, lat, elat);
            else n_pass++;
            n_checks++;
            if (nwr !== ewr || ndl !== edl || nboth !== 0 || opidx !== ((ewr + edl) > 0 ? ei : '0))
                $display("FAIL fill[%0d] memops: got wr=%0d del=%0d idx=%h want wr=%0d del=%0d idx=%h",
                         i, nwr, ndl, opidx, ewr, edl, ei);
            else n_pass++;
            if (i >= 16) begin
                n_checks++;
                if (ri !== 16'h0100) $display("FAIL fill[%0d] slot8: got idx=%h want 0100", i, ri);
                else n_pass++;
            end
        end
        n_checks++;
        if (m_used !== mdl_mask()) $display("FAIL fill used: got %h want %h", m_used, mdl_mask());
        else n_pass++;
    endtask

    task automatic test_random();
        logic [1:0] st, est, op; logic [VW-1:0] rv, ev, val; logic [N-1:0] ri, ei, opidx;
        logic [KW-1:0] key;
        int lat, elat, nwr, ndl, ewr, edl, nboth, nkey, r; bit stable;
        for (int i = 0; i < 40; i++) begin
            r = int'($urandom_range(0, 9));
            op = (r < 4) ? 2'd0 : (r < 7) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            key = ($urandom_range(0, 15) == 0) ? 16'h0 : 16'h100 + KW'($urandom_range(0, 19));
            val = {$urandom, $urandom};
            model(op, key, val, est, ev, ei, elat, ewr, edl);
            send(op, key, val, int'($urandom_range(0, 2)), st, rv, ri, lat, nwr, ndl, opidx, nboth, nkey, stable);
            n_checks++;
            if ({st, rv, ri} !== {est, ev, ei} || stable !== 1'b1)
                $display("FAIL random[%0d] resp: got st=%0d val=%h idx=%h stable=%b want st=%0d val=%h idx=%h",
                         i, st, rv, ri, stable, est, ev, ei);
            else n_pass++;
            n_checks++;
            if (lat !== elat) $display("FAIL random[%0d] latency: got %0d want %0d", i, lat, elat);
            else n_pass++;
            n_checks++;
            if (nwr !== ewr || ndl !== edl || nboth !== 0 || opidx !== ((ewr + edl) > 0 ? ei : '0)
                || (est == 2'd3 && nkey != 0) || m_used !== mdl_mask())
                $display("FAIL random[%0d] memops: got wr=%0d del=%0d idx=%h used=%h want wr=%0d del=%0d used=%h",
                         i, nwr, ndl, opidx, m_used, ewr, edl, mdl_mask());
            else n_pass++;
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            mdl_used[i] = 1'b0; mdl_key[i] = '0; mdl_val[i] = '0;
        end
        test_reset();
        test_directed();
        test_reset_mid_write();
        test_resp_hold();
        test_fill_full();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
